// File: rtl/npc_pkg.sv
// Shared constants and types for the NPC core front end.
// PC width, reset vector, sequential step and the pc_gen state encoding.
package npc_pkg;

  localparam int               XLEN       = 64;
  localparam logic [XLEN-1:0]  RESET_PC   = 64'h8000_0000;
  localparam int               INST_BYTES = 4;
  localparam logic [1:0]       ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_gen_state_t;

endpackage

// File: rtl/pc_gen_if.sv
// PC handshake, redirect and status bundle between pc_gen and the rest of the core.
// master = pc_gen side, slave = fetch/execute/CSR side.
interface pc_gen_if;
  import npc_pkg::*;

  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;
  logic            pc_kill;
  logic            br_redirect;
  logic [XLEN-1:0] br_target;
  logic            trap_redirect;
  logic [XLEN-1:0] trap_target;
  logic            halt_req;
  logic            halted;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;

  modport master (
    output pc, pc_valid, pc_kill, halted, misalign_err, misalign_addr,
    input  pc_ready, br_redirect, br_target, trap_redirect, trap_target, halt_req
  );

  modport slave (
    input  pc, pc_valid, pc_kill, halted, misalign_err, misalign_addr,
    output pc_ready, br_redirect, br_target, trap_redirect, trap_target, halt_req
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer that remembers a redirect arriving while fetch stalls.
// Clear beats capture; a newer redirect overwrites an older one; trap beats branch.
module pc_redirect_buf
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  input  logic            br_redirect,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_redirect,
  input  logic [XLEN-1:0] trap_target,
  output logic            pending,
  output logic [XLEN-1:0] pending_target
);

  logic capture;

  assign capture = enable && !clear && (br_redirect || trap_redirect);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (capture) begin
      pending <= 1'b1;
    end
  end

  // NOTE: the target is payload qualified by pending, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      pending_target <= trap_redirect ? trap_target : br_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generation stage: next-PC selection, stall hold, target
// alignment, halt on PC zero and the BOOT/RUN/HALTED sequencing.
module pc_gen
  import npc_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.master bus
);

  pc_gen_state_t   state, state_next;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] load_pc;
  logic [XLEN-1:0] pending_target;
  logic [XLEN-1:0] mis_addr_q;
  logic            pending;
  logic            use_redirect;
  logic            misaligned;
  logic            running;
  logic            fire;
  logic            load_en;
  logic            halting;
  logic            mis_err_q;

  assign running = (state == RUN);
  assign fire    = running && bus.pc_ready;
  assign seq_pc  = pc_q + XLEN'(INST_BYTES);

  pc_redirect_buf u_redirect_buf (
    .clk            (clk),
    .reset          (reset),
    .enable         (running),
    .clear          (fire || halting),
    .br_redirect    (bus.br_redirect),
    .br_target      (bus.br_target),
    .trap_redirect  (bus.trap_redirect),
    .trap_target    (bus.trap_target),
    .pending        (pending),
    .pending_target (pending_target)
  );

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    raw_target   = pending_target;
    use_redirect = pending;
    if (bus.trap_redirect) begin
      raw_target   = bus.trap_target;
      use_redirect = 1'b1;
    end else if (bus.br_redirect) begin
      raw_target   = bus.br_target;
      use_redirect = 1'b1;
    end
    load_pc    = use_redirect ? (raw_target & ~XLEN'(ALIGN_MASK)) : seq_pc;
    misaligned = use_redirect && ((raw_target[1:0] & ALIGN_MASK) != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Halt request outranks a fire; a zero next PC is never offered.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    halting    = 1'b0;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (bus.halt_req) begin
          state_next = HALTED;
          halting    = 1'b1;
        end else if (fire) begin
          if (load_pc == '0) begin
            state_next = HALTED;
          end else begin
            load_en = 1'b1;
          end
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      mis_err_q  <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_err_q <= load_en && misaligned;
      if (load_en) begin
        pc_q <= load_pc;
        if (misaligned) begin
          mis_addr_q <= raw_target;
        end
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = running;
  assign bus.pc_kill       = running && (pending || bus.trap_redirect || bus.br_redirect);
  assign bus.halted        = (state == HALTED);
  assign bus.misalign_err  = mis_err_q;
  assign bus.misalign_addr = mis_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a per-cycle vector table plus hand-written
// sequences for reset-in-HALTED, BOOT-ignore and halt with a pending redirect.
module tb_pc_gen;
  import npc_pkg::*;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [63:0] bt;
    logic        trap;
    logic [63:0] tt;
    logic        halt;
    logic [63:0] pc;
    logic        valid;
    logic        kill;
    logic        halted;
    logic        mis;
    logic [63:0] maddr;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic        valid;
    logic        kill;
    logic        halted;
    logic        mis;
    logic [63:0] maddr;
  } exp_t;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];
  vec_t vecs[$];

  pc_gen_if bus ();

  pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rdy, input logic br, input logic [63:0] bt,
                              input logic trap, input logic [63:0] tt, input logic halt,
                              input logic [63:0] pc, input logic valid, input logic kill,
                              input logic halted, input logic mis, input logic [63:0] maddr);
    vec_t v;
    v = '{rdy: rdy, br: br, bt: bt, trap: trap, tt: tt, halt: halt,
          pc: pc, valid: valid, kill: kill, halted: halted, mis: mis, maddr: maddr};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, checks outputs before the next edge, then
  // steps past that edge.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    bus.pc_ready      = v.rdy;
    bus.br_redirect   = v.br;
    bus.br_target     = v.bt;
    bus.trap_redirect = v.trap;
    bus.trap_target   = v.tt;
    bus.halt_req      = v.halt;
    exp_q.push_back('{pc: v.pc, valid: v.valid, kill: v.kill,
                      halted: v.halted, mis: v.mis, maddr: v.maddr});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, " pc"},       bus.pc,                  e.pc);
    check({tag, " pc_valid"}, {63'd0, bus.pc_valid},   {63'd0, e.valid});
    check({tag, " pc_kill"},  {63'd0, bus.pc_kill},    {63'd0, e.kill});
    check({tag, " halted"},   {63'd0, bus.halted},     {63'd0, e.halted});
    check({tag, " mis_err"},  {63'd0, bus.misalign_err}, {63'd0, e.mis});
    if (e.mis) check({tag, " mis_addr"}, bus.misalign_addr, e.maddr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    bus.pc_ready      = 1'b0;
    bus.br_redirect   = 1'b0;
    bus.br_target     = '0;
    bus.trap_redirect = 1'b0;
    bus.trap_target   = '0;
    bus.halt_req      = 1'b0;

    //            rdy br bt                      trap tt                   halt  pc                      vld kill hlt mis maddr
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0000,          0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0000,          1, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0004,          1, 0, 0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0008,          1, 0, 0, 0, 64'h0));
    vecs.push_back(mk(0, 1, 64'h8000_0100,         0, 64'h0,             0, 64'h8000_0008,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0008,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0008,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0100,          1, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 64'h8000_0200,         1, 64'h8000_1000,     0, 64'h8000_0104,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 64'h8000_0102,         0, 64'h0,             0, 64'h8000_1000,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0100,          1, 0, 0, 1, 64'h8000_0102));
    vecs.push_back(mk(0, 1, 64'h8000_3000,         1, 64'h8000_2000,     0, 64'h8000_0104,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_0104,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(0, 1, 64'h8000_4000,         0, 64'h0,             0, 64'h8000_2000,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(0, 1, 64'h8000_5004,         0, 64'h0,             0, 64'h8000_2000,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_2000,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'h8000_5004,          1, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,           0, 64'h8000_5008,          1, 1, 0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 64'h8000_0000,         1, 64'h8000_0040,     1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h0,                 0, 64'h0,             0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 0, 64'h0));

    @(negedge clk);
    check("rst pc",       bus.pc,                     64'h8000_0000);
    check("rst pc_valid", {63'd0, bus.pc_valid},      64'd0);
    check("rst pc_kill",  {63'd0, bus.pc_kill},       64'd0);
    check("rst halted",   {63'd0, bus.halted},        64'd0);
    check("rst mis_err",  {63'd0, bus.misalign_err},  64'd0);
    check("rst mis_addr", bus.misalign_addr,          64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Reset asserted while HALTED takes effect without waiting for a clock edge.
    reset = 1'b1;
    #1;
    check("hrst pc",       bus.pc,                    64'h8000_0000);
    check("hrst halted",   {63'd0, bus.halted},       64'd0);
    check("hrst pc_valid", {63'd0, bus.pc_valid},     64'd0);
    check("hrst mis_addr", bus.misalign_addr,         64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // BOOT ignores halt and redirects; then halt while a redirect is pending.
    apply("boot",  mk(1, 1, 64'h8000_0300, 0, 64'h0, 1, 64'h8000_0000, 0, 0, 0, 0, 64'h0));
    apply("run0",  mk(0, 0, 64'h0,          0, 64'h0, 0, 64'h8000_0000, 1, 0, 0, 0, 64'h0));
    apply("pend",  mk(0, 1, 64'h8000_0400,  0, 64'h0, 0, 64'h8000_0000, 1, 1, 0, 0, 64'h0));
    apply("hreq",  mk(0, 0, 64'h0,          0, 64'h0, 1, 64'h8000_0000, 1, 1, 0, 0, 64'h0));
    apply("hlt0",  mk(1, 0, 64'h0,          0, 64'h0, 0, 64'h8000_0000, 0, 0, 1, 0, 64'h0));
    apply("hlt1",  mk(1, 0, 64'h0,          1, 64'h8000_0800, 0, 64'h8000_0000, 0, 0, 1, 0, 64'h0));

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard: %0d expected entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generation stage for the NPC core. Sits directly upstream of the instruction-fetch stage and feeds it one PC per accepted handshake.
- Selects the next PC from sequential, branch/jump redirect, trap redirect or a buffered (pending) redirect.
- Holds the offered PC stable while fetch stalls.
- Owns the halt-on-PC-zero condition, so fetch stays a pure memory-read stage.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h8000_0000, first PC offered after reset.
- INST_BYTES, 4, sequential increment. No compressed ISA.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- pc  out  XLEN  PC offered to fetch.
- pc_valid  out  1  pc is valid this cycle.
- pc_ready  in  1  fetch accepts pc. Fire = pc_valid & pc_ready.
- pc_kill  out  1  offered pc is wrong-path; fetch must discard its instruction.
- br_redirect  in  1  branch/jump taken, from execute.
- br_target  in  XLEN  branch/jump target.
- trap_redirect  in  1  trap/mret redirect, from CSR unit.
- trap_target  in  XLEN  mtvec/mepc target.
- halt_req  in  1  ebreak retired; stop fetching.
- halted  out  1  core stopped (sticky until reset).
- misalign_err  out  1  one-cycle pulse: a redirect target had [1:0]!=0.
- misalign_addr  out  XLEN  raw offending target; valid with misalign_err.

Behaviour:
- Reset (async, active-high) sets: pc=RESET_PC, pc_valid=0, pc_kill=0, halted=0, misalign_err=0, misalign_addr=0, pending=0, state=BOOT. Reset asserted mid-operation discards any pending redirect immediately.
- States: BOOT, RUN, HALTED.
- BOOT: exactly one cycle after reset deasserts, then RUN. pc_valid=0 in BOOT.
- RUN: pc_valid=1. pc and pc_valid must not change while pc_valid & !pc_ready (stability rule).
- Next-PC priority on fire: trap_target > br_target > pending_target > pc+INST_BYTES. Loaded PC appears on pc the next cycle (latency 1). pending is cleared on fire.
- Redirect while not firing: pending_target <= trap_target if trap_redirect, else br_target. A newer redirect overwrites an older pending one. pc holds.
- pc_kill (combinational) = pc_valid & (pending | trap_redirect | br_redirect).
- Target alignment: any selected redirect target is loaded with bits [1:0] forced to 0. If the raw bits [1:0]!=0, misalign_err pulses for one cycle coincident with the new pc, with misalign_addr = raw target. The alignment check applies when the target is loaded, including from pending.
- Sequential add wraps modulo 2^XLEN.
- Halt on PC zero: if the value to be loaded into pc is 0 (redirect or wrap from 64'hFFFF_FFFF_FFFF_FFFC), go to HALTED instead of offering it.
- halt_req: in RUN, next edge goes to HALTED regardless of fire or redirects. halt_req has priority over everything.
- HALTED: pc_valid=0, pc_kill=0, halted=1, pc frozen at its last value. halt_req and redirect inputs are ignored. Only reset exits HALTED.
- halt_req or redirects during BOOT are ignored.
- Simultaneous br_redirect and trap_redirect: trap wins, in both the fire path and the pending path.

Decomposition:
- Package npc_pkg holds: XLEN, RESET_PC, INST_BYTES, the pc_gen_state_t enum {BOOT, RUN, HALTED}, and the 2-bit alignment mask constant.
- One sub-module: pc_redirect_buf. It is the single-entry pending-redirect register with priority merge and clear-on-fire, and outputs pending/pending_target.
- Next-PC mux, alignment check and FSM stay in pc_gen. Expected size is about 150–250 lines total.

Test Plan:
- Reset release, pc_ready=1 constantly -> pc_valid=0 for 1 cycle; then pc = 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; misalign_err=0.
- pc_ready=0 for 3 cycles at pc 0x80000008 with br_redirect=1, br_target=0x80000100 in the 2nd stall cycle -> pc stays 0x80000008; pc_kill=1 from that cycle on. After pc_ready=1 fires, next pc=0x80000100 and pc_kill=0.
- Same cycle trap_redirect=1 (0x80001000) and br_redirect=1 (0x80000200), pc_ready=1 -> next pc=0x80001000.
- br_target=0x80000102 on fire -> next pc=0x80000100; misalign_err=1 for exactly one cycle; misalign_addr=0x80000102.
- Redirect to 0xFFFFFFFFFFFFFFFC, then fire -> next cycle pc_valid=0, halted=1, pc frozen at 0xFFFFFFFFFFFFFFFC.
- halt_req=1 while stalled with a pending redirect -> HALTED next cycle, halted=1; redirect is lost. Asserting reset mid-HALTED -> immediate pc=0x80000000, halted=0, BOOT.
